freelist_alloc: RTL and testbench

- Physical-register free list and allocator for the 4-wide rename stage.
- Holds free physical register numbers in a circular buffer, grants 0-4 registers per cycle to rename and accepts 0-4 released registers per cycle from commit.
- Drives the busy table's 4-wide set bus: every allocated register is marked busy.
- Physical register 0 is hard-wired and never stored, allocated or released.

---
 rtl/freelist_alloc.sv | 139 +++++++++++++
 tb/tb_freelist_alloc.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/freelist_alloc.sv
// freelist_alloc: physical-register free list and 4-wide allocator for rename.
// A circular buffer holds free physical register numbers. Up to four
// registers are granted per cycle (all-or-nothing) and up to four released
// registers are accepted per cycle from commit. Every granted register is
// also driven onto the busy-table set bus. Physical register 0 is
// hard-wired: it is never stored, allocated or released.
//
// Optional build macro FREELIST_STATS_EN adds o_stall_cnt, a saturating
// count of cycles where rename asked for registers and was refused.
module freelist_alloc #(
  parameter int WIDTH = 6,
  parameter int ARCH  = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [2:0]           i_req_n,
  output logic                 o_grant,
  output logic [4*WIDTH-1:0]   o_alloc4x,
  output logic [4*WIDTH-1:0]   o_setAddr4x,
  input  logic [3:0]           i_free_vld,
  input  logic [4*WIDTH-1:0]   i_free4x,
  output logic [WIDTH-1:0]     o_count,
  output logic                 o_empty,
  output logic                 o_ovf
`ifdef FREELIST_STATS_EN
  ,
  output logic [15:0]          o_stall_cnt
`endif
);

  localparam int SIZE = 1 << WIDTH;

  logic [WIDTH-1:0] buffer [SIZE];
  logic [WIDTH-1:0] head;
  logic [WIDTH-1:0] tail;
  logic [WIDTH-1:0] count;
  logic             ovf;

  logic [2:0]       req_eff;
  logic [2:0]       granted;
  logic [2:0]       acc_cnt;
  logic             drop;
  logic [3:0]       wr_en;
  logic [WIDTH-1:0] wr_idx  [4];
  logic [WIDTH-1:0] wr_data [4];
  logic [WIDTH:0]   lvl_base;
  logic [WIDTH-1:0] count_next;

  // Clamp the request, decide the grant and present the head entries.
  always_comb begin
    req_eff   = (i_req_n > 3'd4) ? 3'd4 : i_req_n;
    o_grant   = (WIDTH'(req_eff) <= count);
    granted   = o_grant ? req_eff : 3'd0;
    o_alloc4x = '0;
    for (int k = 0; k < 4; k++) begin
      if (3'(k) < req_eff) begin
        o_alloc4x[k*WIDTH +: WIDTH] = buffer[head + WIDTH'(k)];
      end
    end
    o_setAddr4x = o_grant ? o_alloc4x : '0;
  end

  // Compact valid nonzero releases in slot order; stop accepting at SIZE-1.
  always_comb begin
    acc_cnt  = 3'd0;
    drop     = 1'b0;
    wr_en    = '0;
    lvl_base = {1'b0, count} - (WIDTH+1)'(granted);
    for (int k = 0; k < 4; k++) begin
      wr_idx[k]  = '0;
      wr_data[k] = '0;
    end
    for (int k = 0; k < 4; k++) begin
      if (i_free_vld[k] && (i_free4x[k*WIDTH +: WIDTH] != '0)) begin
        if ((lvl_base + (WIDTH+1)'(acc_cnt)) < (WIDTH+1)'(SIZE - 1)) begin
          wr_en[k]   = 1'b1;
          wr_idx[k]  = tail + WIDTH'(acc_cnt);
          wr_data[k] = i_free4x[k*WIDTH +: WIDTH];
          acc_cnt    = acc_cnt + 3'd1;
        end else begin
          drop = 1'b1;
        end
      end
    end
    count_next = count - WIDTH'(granted) + WIDTH'(acc_cnt);
  end

  // Buffer storage: reset to the post-ARCH register numbers, then written at tail.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < SIZE; i++) begin
        buffer[i] <= (i < SIZE - ARCH) ? WIDTH'(ARCH + i) : '0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (wr_en[k]) begin
          buffer[wr_idx[k]] <= wr_data[k];
        end
      end
    end
  end

  // Pointer, occupancy and sticky overflow state.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      head  <= '0;
      tail  <= WIDTH'(SIZE - ARCH);
      count <= WIDTH'(SIZE - ARCH);
      ovf   <= 1'b0;
    end else begin
      head  <= head + WIDTH'(granted);
      tail  <= tail + WIDTH'(acc_cnt);
      count <= count_next;
      if (drop) begin
        ovf <= 1'b1;
      end
    end
  end

`ifdef FREELIST_STATS_EN
  logic [15:0] stall_cnt;

  // Saturating count of refused nonzero requests.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      stall_cnt <= '0;
    end else if ((req_eff != 3'd0) && !o_grant && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

  assign o_stall_cnt = stall_cnt;
`endif

  assign o_count = count;
  assign o_empty = (count == '0);
  assign o_ovf   = ovf;

endmodule

// File: tb/tb_freelist_alloc.sv
// tb_freelist_alloc: directed table-driven bench for freelist_alloc at
// default parameters (WIDTH=6, ARCH=32), plus hand-written sequences for
// fill/overflow, wrap-around and mid-burst reset.
module tb_freelist_alloc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  req_n;
  logic        grant;
  logic [23:0] alloc4x;
  logic [23:0] set4x;
  logic [3:0]  free_vld;
  logic [23:0] free4x;
  logic [5:0]  count;
  logic        empty;
  logic        ovf;
`ifdef FREELIST_STATS_EN
  logic [15:0] stall_cnt;
`endif

  always #5 clk = ~clk;

  freelist_alloc #(.WIDTH(6), .ARCH(32)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_req_n     (req_n),
    .o_grant     (grant),
    .o_alloc4x   (alloc4x),
    .o_setAddr4x (set4x),
    .i_free_vld  (free_vld),
    .i_free4x    (free4x),
    .o_count     (count),
    .o_empty     (empty),
    .o_ovf       (ovf)
`ifdef FREELIST_STATS_EN
    ,
    .o_stall_cnt (stall_cnt)
`endif
  );

  typedef struct {
    logic [2:0]  req;
    logic [3:0]  vld;
    logic [23:0] free;
    logic        grant;
    logic [23:0] set;
    logic [5:0]  cnt;
    logic        emp;
    logic        ovf;
  } vec_t;

  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic logic [23:0] pk(int a, int b, int c, int d);
    return {6'(d), 6'(c), 6'(b), 6'(a)};
  endfunction

  function automatic vec_t mk(logic [2:0] rq, logic [3:0] vl, logic [23:0] fr,
                              logic gr, logic [23:0] st, int cn, logic em, logic ov);
    vec_t v;
    v.req = rq; v.vld = vl; v.free = fr; v.grant = gr;
    v.set = st; v.cnt = 6'(cn); v.emp = em; v.ovf = ov;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs just after the falling edge, settle, sample.
  task automatic drive(logic rs, logic [2:0] rq, logic [3:0] vl, logic [23:0] fr);
    @(negedge clk);
    rst_n    = rs;
    req_n    = rq;
    free_vld = vl;
    free4x   = fr;
    #1;
  endtask

  task automatic check_outs(string tag, logic gr, logic [23:0] st, int cn,
                            logic em, logic ov);
    chk({tag, ".grant"}, 32'(grant), 32'(gr));
    chk({tag, ".set"},   32'(set4x), 32'(st));
    if (gr) chk({tag, ".alloc"}, 32'(alloc4x), 32'(st));
    chk({tag, ".count"}, 32'(count), 32'(cn));
    chk({tag, ".empty"}, 32'(empty), 32'(em));
    chk({tag, ".ovf"},   32'(ovf),   32'(ov));
  endtask

  initial begin
    rst_n = 1'b0; req_n = '0; free_vld = '0; free4x = '0;

    // Drain all 32 reset registers 4 at a time, then run the empty corners.
    for (int j = 0; j < 8; j++)
      vecs.push_back(mk(3'd4, 4'h0, '0, 1'b1,
                        pk(32+4*j, 33+4*j, 34+4*j, 35+4*j), 32-4*j, 1'b0, 1'b0));
    vecs.push_back(mk(3'd4, 4'h0, '0, 1'b0, '0, 0, 1'b1, 1'b0));
    vecs.push_back(mk(3'd0, 4'hF, pk(5, 0, 7, 9), 1'b1, '0, 0, 1'b1, 1'b0));
    vecs.push_back(mk(3'd3, 4'h0, '0, 1'b1, pk(5, 7, 9, 0), 3, 1'b0, 1'b0));
    vecs.push_back(mk(3'd0, 4'h3, pk(10, 11, 0, 0), 1'b1, '0, 0, 1'b1, 1'b0));
    vecs.push_back(mk(3'd3, 4'h3, pk(12, 13, 0, 0), 1'b0, '0, 2, 1'b0, 1'b0));
    vecs.push_back(mk(3'd3, 4'h0, '0, 1'b1, pk(10, 11, 12, 0), 4, 1'b0, 1'b0));
    vecs.push_back(mk(3'd7, 4'h0, '0, 1'b0, '0, 1, 1'b0, 1'b0));
    vecs.push_back(mk(3'd0, 4'h0, pk(20, 21, 22, 23), 1'b1, '0, 1, 1'b0, 1'b0));

    repeat (2) @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      drive(1'b1, vecs[i].req, vecs[i].vld, vecs[i].free);
      check_outs($sformatf("vec%0d", i), vecs[i].grant, vecs[i].set,
                 vecs[i].cnt, vecs[i].emp, vecs[i].ovf);
    end

    // Fill from 1 up to 61 with four releases per cycle.
    for (int j = 0; j < 15; j++) begin
      drive(1'b1, 3'd0, 4'hF, pk(4*j+1, 4*j+2, 4*j+3, 4*j+4));
      chk($sformatf("fill%0d.count", j), 32'(count), 32'(1 + 4*j));
    end
    // Only two of these four fit before SIZE-1.
    drive(1'b1, 3'd0, 4'hF, pk(61, 62, 63, 63));
    check_outs("fill_last", 1'b1, '0, 61, 1'b0, 1'b0);
    // Full: both releases dropped, overflow now sticky.
    drive(1'b1, 3'd0, 4'h3, pk(40, 41, 0, 0));
    check_outs("full_drop", 1'b1, '0, 63, 1'b0, 1'b1);
    // Grant across the wrap point while releasing four into the freed room.
    drive(1'b1, 3'd4, 4'hF, pk(20, 21, 22, 23));
    check_outs("full_swap", 1'b1, pk(13, 1, 2, 3), 63, 1'b0, 1'b1);
    drive(1'b1, 3'd4, 4'h0, '0);
    check_outs("after_swap", 1'b1, pk(4, 5, 6, 7), 63, 1'b0, 1'b1);
`ifdef FREELIST_STATS_EN
    chk("stall_cnt", 32'(stall_cnt), 32'd3);
`endif

    // Reset in the middle of a grant plus release burst.
    drive(1'b0, 3'd4, 4'hF, pk(1, 2, 3, 4));
    drive(1'b1, 3'd4, 4'h0, '0);
    check_outs("post_rst", 1'b1, pk(32, 33, 34, 35), 32, 1'b0, 1'b0);
`ifdef FREELIST_STATS_EN
    chk("post_rst.stall_cnt", 32'(stall_cnt), 32'd0);
`endif
    drive(1'b1, 3'd0, 4'h0, '0);
    chk("post_rst2.count", 32'(count), 32'd28);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
